tile_pixel_generator: RTL



---
 rtl/tile_pixel_generator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tile_pixel_generator.sv
// Tile/text-mode pixel generator: maps VGA coordinates through scale and scroll into a
// tile map and fetches tile, attribute, font and palette over a four-step sub-pixel schedule.
module tile_pixel_generator #(
  parameter int COL_BITS    = 6,
  parameter int ROW_BITS    = 5,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   divider_count,
  input  logic                         vga_blank,
  input  logic [9:0]                   cycle,
  input  logic [8:0]                   scanline,
  input  logic [9:0]                   scroll_x,
  input  logic [8:0]                   scroll_y,
  input  logic                         mode,
  output logic [COL_BITS+ROW_BITS-1:0] tile_memory_read_addr,
  output logic                         tile_memory_read_enable,
  input  logic [7:0]                   tile_memory_read_data,
  output logic [COL_BITS+ROW_BITS-1:0] attribute_memory_read_addr,
  output logic                         attribute_memory_read_enable,
  input  logic [7:0]                   attribute_memory_read_data,
  output logic [11:0]                  font_memory_read_addr,
  output logic                         font_memory_read_enable,
  input  logic [7:0]                   font_memory_read_data,
  output logic [3:0]                   color_memory_read_addr,
  output logic                         color_memory_read_enable,
  input  logic [7:0]                   color_memory_read_data,
  output logic [7:0]                   pixel_data,
  output logic                         pixel_valid
);

  localparam int AW  = COL_BITS + ROW_BITS;
  localparam int SXW = COL_BITS + 3;
  localparam int SYW = ROW_BITS + 3;

  // Tracks how far the current fetch has progressed in order, so a pixel is only
  // presented after an uninterrupted 0->3 sequence.
  typedef enum logic [1:0] {PH_IDLE, PH_S0, PH_S1, PH_S2} phase_e;

  phase_e          phase_q, phase_d;
  logic            have_pixel_q, have_pixel_d;
  logic            mode_q, mode_d;
  logic [2:0]      fine_col_q, fine_col_d;
  logic [2:0]      fine_row_q, fine_row_d;
  logic            blank_q, blank_d;
  logic [7:0]      tile_q, tile_d;
  logic [7:0]      attr_q, attr_d;
  logic [7:0]      p0_q, p0_d;
  logic [AW-1:0]   map_addr_q, map_addr_d;
  logic            map_en_q, map_en_d;
  logic [11:0]     font_addr_q, font_addr_d;
  logic            font_en_q, font_en_d;
  logic [3:0]      color_addr_q, color_addr_d;
  logic            color_en_q, color_en_d;
  logic [7:0]      pixel_data_q, pixel_data_d;
  logic            pixel_valid_q, pixel_valid_d;

  logic [SXW-1:0]  sx;
  logic [SYW-1:0]  sy;
  logic [2:0]      bit_sel;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned
    // and no latch can be inferred.
    phase_d       = phase_q;
    have_pixel_d  = have_pixel_q;
    mode_d        = mode_q;
    fine_col_d    = fine_col_q;
    fine_row_d    = fine_row_q;
    blank_d       = blank_q;
    tile_d        = tile_q;
    attr_d        = attr_q;
    p0_d          = p0_q;
    map_addr_d    = map_addr_q;
    map_en_d      = 1'b0;
    font_addr_d   = font_addr_q;
    font_en_d     = 1'b0;
    color_addr_d  = color_addr_q;
    color_en_d    = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;

    // Truncating sums give the map wrap-around for free.
    sx      = SXW'(cycle >> SCALE_SHIFT) + SXW'(scroll_x);
    sy      = SYW'(scanline >> SCALE_SHIFT) + SYW'(scroll_y);
    bit_sel = ~fine_col_q;

    case (divider_count)
      3'd0: begin
        mode_d     = mode;
        fine_col_d = sx[2:0];
        fine_row_d = sy[2:0];
        blank_d    = vga_blank;
        map_addr_d = {sy[SYW-1:3], sx[SXW-1:3]};
        map_en_d   = 1'b1;
        if (have_pixel_q) begin
          pixel_data_d  = blank_q ? 8'h00 : color_memory_read_data;
          pixel_valid_d = 1'b1;
        end
        have_pixel_d = 1'b0;
        phase_d      = PH_S0;
      end
      3'd1: begin
        tile_d      = tile_memory_read_data;
        attr_d      = attribute_memory_read_data;
        font_addr_d = {tile_memory_read_data, fine_row_q, 1'b0};
        font_en_d   = 1'b1;
        phase_d     = (phase_q == PH_S0) ? PH_S1 : PH_IDLE;
      end
      3'd2: begin
        p0_d = font_memory_read_data;
        if (mode_q) begin
          font_addr_d = {tile_q, fine_row_q, 1'b1};
          font_en_d   = 1'b1;
        end
        phase_d = (phase_q == PH_S1) ? PH_S2 : PH_IDLE;
      end
      3'd3: begin
        if (mode_q)
          color_addr_d = {attr_q[1:0], font_memory_read_data[bit_sel], p0_q[bit_sel]};
        else
          color_addr_d = p0_q[bit_sel] ? attr_q[7:4] : attr_q[3:0];
        color_en_d = 1'b1;
        if (phase_q == PH_S2) have_pixel_d = 1'b1;
        phase_d = PH_IDLE;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= PH_IDLE;
      have_pixel_q  <= 1'b0;
      mode_q        <= 1'b0;
      fine_col_q    <= 3'd0;
      fine_row_q    <= 3'd0;
      blank_q       <= 1'b0;
      tile_q        <= 8'h00;
      attr_q        <= 8'h00;
      p0_q          <= 8'h00;
      map_addr_q    <= '0;
      map_en_q      <= 1'b0;
      font_addr_q   <= 12'h000;
      font_en_q     <= 1'b0;
      color_addr_q  <= 4'h0;
      color_en_q    <= 1'b0;
      pixel_data_q  <= 8'h00;
      pixel_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      have_pixel_q  <= have_pixel_d;
      mode_q        <= mode_d;
      fine_col_q    <= fine_col_d;
      fine_row_q    <= fine_row_d;
      blank_q       <= blank_d;
      tile_q        <= tile_d;
      attr_q        <= attr_d;
      p0_q          <= p0_d;
      map_addr_q    <= map_addr_d;
      map_en_q      <= map_en_d;
      font_addr_q   <= font_addr_d;
      font_en_q     <= font_en_d;
      color_addr_q  <= color_addr_d;
      color_en_q    <= color_en_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign tile_memory_read_addr        = map_addr_q;
  assign tile_memory_read_enable      = map_en_q;
  assign attribute_memory_read_addr   = map_addr_q;
  assign attribute_memory_read_enable = map_en_q;
  assign font_memory_read_addr        = font_addr_q;
  assign font_memory_read_enable      = font_en_q;
  assign color_memory_read_addr       = color_addr_q;
  assign color_memory_read_enable     = color_en_q;
  assign pixel_data                   = pixel_data_q;
  assign pixel_valid                  = pixel_valid_q;

endmodule
